// File: rtl/sha_rx_ctrl.sv
// ============================================================================
// sha_rx_ctrl: frames UART bytes (A5, L, message) into one padded SHA-256
// block, streams it to the hash core as 16 big-endian words, then starts it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sha_rx_ctrl #(
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    input  logic        i_Core_Ready,
    input  logic        i_Core_Done,
    output logic        o_Word_Valid,
    output logic [3:0]  o_Word_Idx,
    output logic [31:0] o_Word,
    output logic        o_Start,
    output logic        o_Busy,
    output logic        o_Err,
    output logic [1:0]  o_Err_Code
);

    localparam int         c_TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [7:0] c_HEADER   = 8'hA5;
    localparam logic [7:0] c_MAX_LEN  = 8'd55;
    localparam logic [1:0] c_ERR_LEN  = 2'b01;
    localparam logic [1:0] c_ERR_TMO  = 2'b10;
    localparam logic [1:0] c_ERR_OVR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_PAD   = 3'd3,
        S_LOAD  = 3'd4,
        S_START = 3'd5,
        S_WAIT  = 3'd6
    } state_t;

    state_t          r_State;
    state_t          w_Next;
    logic [5:0]      r_Len;
    logic [5:0]      r_Cnt;
    logic [3:0]      r_Idx;
    logic [c_TW-1:0] r_Tmo;
    logic [7:0]      r_Buf [0:63];
    logic            r_Err;
    logic [1:0]      r_Err_Code;

    logic            w_Tmo_Hit;
    logic            w_Set_Err;
    logic            w_Clr_Err;
    logic [1:0]      w_Err_Code;
    logic            w_In_Frame;

    assign w_In_Frame = (r_State == S_LEN) || (r_State == S_DATA);
    assign w_Tmo_Hit  = w_In_Frame && !i_Rx_DV &&
                        (r_Tmo == c_TW'(TIMEOUT_CLKS - 1));

    always_comb begin
        w_Next     = r_State;
        w_Set_Err  = 1'b0;
        w_Clr_Err  = 1'b0;
        w_Err_Code = 2'b00;
        case (r_State)
            S_IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == c_HEADER)) begin
                    w_Next    = S_LEN;
                    w_Clr_Err = 1'b1;
                end
            end
            S_LEN: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte > c_MAX_LEN) begin
                        w_Next     = S_IDLE;
                        w_Set_Err  = 1'b1;
                        w_Err_Code = c_ERR_LEN;
                    end else if (i_Rx_Byte == 8'd0) begin
                        w_Next = S_PAD;
                    end else begin
                        w_Next = S_DATA;
                    end
                end else if (w_Tmo_Hit) begin
                    w_Next     = S_IDLE;
                    w_Set_Err  = 1'b1;
                    w_Err_Code = c_ERR_TMO;
                end
            end
            S_DATA: begin
                if (i_Rx_DV) begin
                    if (r_Cnt == (r_Len - 6'd1)) begin
                        w_Next = S_PAD;
                    end
                end else if (w_Tmo_Hit) begin
                    w_Next     = S_IDLE;
                    w_Set_Err  = 1'b1;
                    w_Err_Code = c_ERR_TMO;
                end
            end
            S_PAD: begin
                if (i_Core_Ready) begin
                    w_Next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_Idx == 4'd15) begin
                    w_Next = S_START;
                end
            end
            S_START: begin
                w_Next = S_WAIT;
            end
            S_WAIT: begin
                if (i_Core_Done) begin
                    w_Next = S_IDLE;
                end
            end
            default: begin
                w_Next = S_IDLE;
            end
        endcase
        // Bytes arriving once the frame is complete are dropped, never stored.
        if (i_Rx_DV && !(r_State == S_IDLE) && !w_In_Frame) begin
            w_Set_Err  = 1'b1;
            w_Err_Code = c_ERR_OVR;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State    <= S_IDLE;
            r_Len      <= 6'd0;
            r_Cnt      <= 6'd0;
            r_Idx      <= 4'd0;
            r_Tmo      <= '0;
            r_Err      <= 1'b0;
            r_Err_Code <= 2'b00;
        end else begin
            r_State <= w_Next;

            if (w_In_Frame && !i_Rx_DV) begin
                r_Tmo <= r_Tmo + c_TW'(1);
            end else begin
                r_Tmo <= '0;
            end

            if ((r_State == S_LEN) && i_Rx_DV) begin
                r_Len <= i_Rx_Byte[5:0];
            end

            if (r_State != S_DATA) begin
                r_Cnt <= 6'd0;
            end else if (i_Rx_DV) begin
                r_Cnt <= r_Cnt + 6'd1;
            end

            if (r_State == S_LOAD) begin
                r_Idx <= r_Idx + 4'd1;
            end else begin
                r_Idx <= 4'd0;
            end

            if (w_Set_Err) begin
                r_Err      <= 1'b1;
                r_Err_Code <= w_Err_Code;
            end else if (w_Clr_Err) begin
                r_Err      <= 1'b0;
                r_Err_Code <= 2'b00;
            end
        end
    end

    // PAD rewrites every byte past the message, so stale data cannot survive.
    always_ff @(posedge i_Clock) begin
        if ((r_State == S_DATA) && i_Rx_DV) begin
            r_Buf[r_Cnt] <= i_Rx_Byte;
        end
        if (r_State == S_PAD) begin
            for (int i = 0; i < 64; i++) begin
                if (i == int'(r_Len)) begin
                    r_Buf[i] <= 8'h80;
                end else if (i == 62) begin
                    r_Buf[i] <= {7'd0, r_Len[5]};
                end else if (i == 63) begin
                    r_Buf[i] <= {r_Len[4:0], 3'b000};
                end else if (i > int'(r_Len)) begin
                    r_Buf[i] <= 8'h00;
                end
            end
        end
    end

    always_comb begin
        o_Word_Valid = (r_State == S_LOAD);
        o_Word_Idx   = 4'd0;
        o_Word       = 32'd0;
        if (o_Word_Valid) begin
            o_Word_Idx = r_Idx;
            o_Word     = {r_Buf[{r_Idx, 2'b00}], r_Buf[{r_Idx, 2'b01}],
                          r_Buf[{r_Idx, 2'b10}], r_Buf[{r_Idx, 2'b11}]};
        end
    end

    assign o_Start    = (r_State == S_START);
    assign o_Busy     = (r_State != S_IDLE);
    assign o_Err      = r_Err;
    assign o_Err_Code = r_Err_Code;

endmodule

`default_nettype wire

// File: tb/tb_sha_rx_ctrl.sv
// ============================================================================
// tb_sha_rx_ctrl: frame-level reference model (padded block per frame) with a
// per-cycle monitor on the word/start outputs, plus directed literal checks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sha_rx_ctrl;

    localparam int c_TMO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        core_ready;
    logic        core_done;
    logic        o_Word_Valid;
    logic [3:0]  o_Word_Idx;
    logic [31:0] o_Word;
    logic        o_Start;
    logic        o_Busy;
    logic        o_Err;
    logic [1:0]  o_Err_Code;

    always #5 clk = ~clk;

    sha_rx_ctrl #(.TIMEOUT_CLKS(c_TMO)) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Rx_DV      (rx_dv),
        .i_Rx_Byte    (rx_byte),
        .i_Core_Ready (core_ready),
        .i_Core_Done  (core_done),
        .o_Word_Valid (o_Word_Valid),
        .o_Word_Idx   (o_Word_Idx),
        .o_Word       (o_Word),
        .o_Start      (o_Start),
        .o_Busy       (o_Busy),
        .o_Err        (o_Err),
        .o_Err_Code   (o_Err_Code)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [35:0] exp_q [$];
    logic [35:0] e;
    bit          start_pend = 0;
    int          n_starts   = 0;
    logic [31:0] cap [0:15];
    logic [7:0]  msg [0:55];
    logic        exp_err  = 1'b0;
    logic [1:0]  exp_code = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every word must match the model queue; o_Start only right after word 15.
    always @(negedge clk) begin
        if (rst) begin
            start_pend = 0;
        end else begin
            chk("start", 32'(o_Start), 32'(start_pend));
            if (o_Start) n_starts++;
            start_pend = 0;
            if (o_Word_Valid) begin
                cap[o_Word_Idx] = o_Word;
                if (exp_q.size() == 0) begin
                    chk("word_valid", 32'(o_Word_Valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_idx", 32'(o_Word_Idx), 32'(e[35:32]));
                    chk("word", o_Word, e[31:0]);
                    if (e[35:32] == 4'd15) start_pend = 1;
                end
            end else begin
                chk("idle_word", o_Word, 32'd0);
                chk("idle_idx", 32'(o_Word_Idx), 32'd0);
            end
        end
    end

    // Reference: SHA-256 padding of msg[0..L-1] into 64 bytes, as 16 words.
    task automatic push_block(input int L);
        logic [7:0] blk [0:63];
        longint bits;
        bits = longint'(L) * 8;
        for (int i = 0; i < 64; i++) begin
            if (i < L)        blk[i] = msg[i];
            else if (i == L)  blk[i] = 8'h80;
            else if (i < 56)  blk[i] = 8'h00;
            else              blk[i] = 8'((bits >> (8 * (63 - i))) & 255);
        end
        for (int w = 0; w < 16; w++)
            exp_q.push_back({4'(w), blk[4*w], blk[4*w+1], blk[4*w+2], blk[4*w+3]});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic send_frame(input int L, input int maxgap);
        send_byte(8'hA5);
        exp_err  = 1'b0;
        exp_code = 2'b00;
        gap($urandom_range(maxgap, 0));
        send_byte(8'(L));
        for (int i = 0; i < L; i++) begin
            gap($urandom_range(maxgap, 0));
            send_byte(msg[i]);
        end
    endtask

    task automatic wait_start(input int s0);
        int k = 0;
        while (n_starts == s0 && k < 200) begin
            tick();
            k++;
        end
        chk("start_count", 32'(n_starts - s0), 32'd1);
    endtask

    task automatic finish_done(input int d);
        gap(d);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("busy_after_done", 32'(o_Busy), 32'd0);
    endtask

    task automatic check_err(input string n);
        chk({n, "_err"}, 32'(o_Err), 32'(exp_err));
        chk({n, "_code"}, 32'(o_Err_Code), 32'(exp_code));
    endtask

    task automatic check_outputs_zero(input string n);
        chk({n, "_valid"}, 32'(o_Word_Valid), 32'd0);
        chk({n, "_idx"}, 32'(o_Word_Idx), 32'd0);
        chk({n, "_word"}, o_Word, 32'd0);
        chk({n, "_start"}, 32'(o_Start), 32'd0);
        chk({n, "_busy"}, 32'(o_Busy), 32'd0);
        chk({n, "_err"}, 32'(o_Err), 32'd0);
        chk({n, "_code"}, 32'(o_Err_Code), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int L;
        rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
        core_ready = 1'b1; core_done = 1'b0;
        gap(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        gap(2);

        // A5 03 "abc"
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        s0 = n_starts;
        push_block(3);
        send_frame(3, 2);
        wait_start(s0);
        chk("abc_w0", cap[0], 32'h61626380);
        for (int i = 1; i < 15; i++) chk("abc_wmid", cap[i], 32'h0);
        chk("abc_w15", cap[15], 32'h00000018);
        chk("abc_busy_wait", 32'(o_Busy), 32'd1);
        finish_done(3);
        check_err("abc");

        // A5 00
        s0 = n_starts;
        push_block(0);
        send_frame(0, 0);
        wait_start(s0);
        chk("empty_w0", cap[0], 32'h80000000);
        for (int i = 1; i < 16; i++) chk("empty_wrest", cap[i], 32'h0);
        finish_done(0);

        // Maximum length, then one over
        for (int i = 0; i < 55; i++) msg[i] = 8'(i);
        s0 = n_starts;
        push_block(55);
        send_frame(55, 1);
        wait_start(s0);
        chk("max_w13", cap[13], 32'h34353680);
        chk("max_w14", cap[14], 32'h0);
        chk("max_w15", cap[15], 32'h000001B8);
        finish_done(1);
        send_byte(8'hA5);
        send_byte(8'h38);
        exp_err = 1'b1; exp_code = 2'b01;
        gap(20);
        chk("badlen_busy", 32'(o_Busy), 32'd0);
        check_err("badlen");
        chk("badlen_no_words", 32'(exp_q.size()), 32'd0);

        // Timeout after partial frame: abort on the c_TMO-th silent clock
        s0 = n_starts;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h41);
        exp_err = 1'b0; exp_code = 2'b00;
        gap(c_TMO - 1);
        chk("tmo_busy_before", 32'(o_Busy), 32'd1);
        check_err("tmo_before");
        tick();
        exp_err = 1'b1; exp_code = 2'b10;
        chk("tmo_busy_after", 32'(o_Busy), 32'd0);
        check_err("tmo");
        gap(10);
        chk("tmo_no_start", 32'(n_starts - s0), 32'd0);

        // Reset mid-frame clears the sticky error and the partial frame
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        gap(2);
        rst = 1'b0;
        exp_err = 1'b0; exp_code = 2'b00;
        check_outputs_zero("midreset");
        gap(5);
        msg[0] = 8'hFF;
        s0 = n_starts;
        push_block(1);
        send_frame(1, 0);
        wait_start(s0);
        chk("after_rst_w0", cap[0], 32'hFF800000);
        chk("after_rst_w15", cap[15], 32'h00000008);
        finish_done(2);

        // Overrun in WAIT, cleared by next header; Core_Ready low holds PAD
        msg[0] = 8'h12; msg[1] = 8'h34;
        s0 = n_starts;
        push_block(2);
        send_frame(2, 1);
        wait_start(s0);
        send_byte(8'h77);
        exp_err = 1'b1; exp_code = 2'b11;
        check_err("ovr_wait");
        chk("ovr_busy", 32'(o_Busy), 32'd1);
        finish_done(2);
        check_err("ovr_idle");
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        send_byte(8'hA5);
        exp_err = 1'b0; exp_code = 2'b00;
        check_err("hdr_clear");
        core_ready = 1'b0;
        msg[0] = 8'h5A;
        s0 = n_starts;
        push_block(1);
        send_byte(8'h01);
        send_byte(msg[0]);
        gap(30);
        chk("hold_busy", 32'(o_Busy), 32'd1);
        chk("hold_no_words", 32'(exp_q.size()), 32'd16);
        core_ready = 1'b1;
        wait_start(s0);
        finish_done(1);

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            int rdly;
            if ($urandom_range(4, 0) == 0) begin
                send_byte(8'hA5);
                send_byte(8'($urandom_range(255, 56)));
                exp_err = 1'b1; exp_code = 2'b01;
                tick();
                chk("rnd_badlen_busy", 32'(o_Busy), 32'd0);
                check_err("rnd_badlen");
            end
            L = $urandom_range(55, 0);
            for (int i = 0; i < 56; i++) msg[i] = 8'($urandom);
            rdly = $urandom_range(3, 0);
            if ($urandom_range(3, 0) == 0) begin
                core_done = 1'b1;
                tick();
                core_done = 1'b0;
            end
            s0 = n_starts;
            push_block(L);
            if (rdly != 0) core_ready = 1'b0;
            send_frame(L, 3);
            if (rdly != 0) begin
                gap(rdly);
                if ($urandom_range(1, 0) == 1) begin
                    send_byte(8'($urandom));
                    exp_err = 1'b1; exp_code = 2'b11;
                end
                core_ready = 1'b1;
            end
            wait_start(s0);
            if ($urandom_range(2, 0) == 0) begin
                send_byte(8'($urandom));
                exp_err = 1'b1; exp_code = 2'b11;
            end
            finish_done($urandom_range(4, 0));
            check_err("rnd");
        end

        gap(5);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
